// File: rtl/stream_mux_pkg.sv
// -----------------------------------------------------------------------------
// stream_mux_pkg
// Shared definitions for the stream_mux_rr streaming multiplexer.
//   MODE_FIXED / MODE_RR : encodings of the 'mode' input.
//   next_ptr()           : round-robin pointer successor, wrapping at n_ch-1
//                          (not at a power of two, so odd channel counts work).
// -----------------------------------------------------------------------------
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Successor of channel 'cur' in a ring of n_ch channels.
  function automatic int unsigned next_ptr(input int unsigned cur,
                                           input int unsigned n_ch);
    if ((cur + 32'd1) >= n_ch) begin
      return 32'd0;
    end else begin
      return cur + 32'd1;
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational rotate-priority picker: returns the first requesting channel
// found when searching ptr_i, ptr_i+1, ... with wrap at N_CH-1 -> 0.
// Ports:
//   req_i  [N_CH-1:0] request vector (one bit per channel)
//   ptr_i  [SW-1:0]   highest-priority channel this cycle (must be < N_CH)
//   gnt_o  [SW-1:0]   granted channel index (0 when nothing requests)
//   any_o             at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int N_CH = 4,
  localparam int SW   = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [SW-1:0]   ptr_i,
  output logic [SW-1:0]   gnt_o,
  output logic            any_o
);

  // One extra bit so ptr + offset cannot overflow before the wrap.
  logic [SW:0] sum_s;
  logic [SW:0] idx_s;

  // Rotating search for the first requester starting at the pointer
  always_comb begin
    gnt_o = '0;
    any_o = 1'b0;
    sum_s = '0;
    idx_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      sum_s = {1'b0, ptr_i} + (SW+1)'(i);
      idx_s = (sum_s >= (SW+1)'(N_CH)) ? (sum_s - (SW+1)'(N_CH)) : sum_s;
      if (!any_o && req_i[idx_s[SW-1:0]]) begin
        any_o = 1'b1;
        gnt_o = idx_s[SW-1:0];
      end else begin
        // earlier hit already has priority, or this channel is idle
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// -----------------------------------------------------------------------------
// stream_mux_rr
// N_CH-input, W-bit streaming multiplexer with valid/ready on every port and a
// registered output stage. mode = 0 selects channel 'sel'; mode = 1 arbitrates
// round-robin among valid channels.
// Optional feature macro: STREAM_MUX_PKT_LOCK_EN -- when defined, a packet that
// starts on a channel keeps the grant until its in_last beat transfers.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   mode, sel       grant mode, fixed-mode channel select
//   in_data/last/valid, in_ready   per-channel input streams (flattened data)
//   out_data/last/ch/valid, out_ready  registered output stream
// -----------------------------------------------------------------------------
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int N_CH = 4,
  parameter  int W    = 8,
  localparam int SW   = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [SW-1:0]     sel,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0]   in_last,
  input  logic [N_CH-1:0]   in_valid,
  output logic [N_CH-1:0]   in_ready,
  output logic [W-1:0]      out_data,
  output logic              out_last,
  output logic [SW-1:0]     out_ch,
  output logic              out_valid,
  input  logic              out_ready
);

  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q,  out_data_d;
  logic            out_last_q,  out_last_d;
  logic [SW-1:0]   out_ch_q,    out_ch_d;
  logic [SW-1:0]   ptr_q,       ptr_d;
`ifdef STREAM_MUX_PKT_LOCK_EN
  logic            lock_q,      lock_d;
  logic [SW-1:0]   lock_ch_q,   lock_ch_d;
`endif

  logic            load_s;
  logic [SW-1:0]   rr_gnt_s;
  logic            rr_any_s;
  logic [SW-1:0]   g_s;
  logic            grant_ok_s;
  logic [N_CH-1:0] sel_oh_s;
  logic [W-1:0]    mux_data_s;
  logic            mux_last_s;
  logic            xfer_s;
  logic            ptr_step_s;

  // Output register can take a new beat when empty or being drained.
  assign load_s = ~out_valid_q | out_ready;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req_i (in_valid),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt_s),
    .any_o (rr_any_s)
  );

  // Grant selection: mode mux, with an active packet lock taking precedence
  always_comb begin
    g_s        = '0;
    grant_ok_s = 1'b0;
    if (mode == MODE_RR) begin
      g_s        = rr_gnt_s;
      grant_ok_s = rr_any_s;
    end else begin
      g_s        = sel;
      // sel can exceed N_CH-1 when N_CH is not a power of two
      grant_ok_s = ({1'b0, sel} < (SW+1)'(N_CH));
    end
`ifdef STREAM_MUX_PKT_LOCK_EN
    if (lock_q) begin
      g_s        = lock_ch_q;
      grant_ok_s = 1'b1;
    end else begin
      // no packet in flight: keep the mode grant
      grant_ok_s = grant_ok_s;
    end
`endif
  end

  // One-hot decode of the grant and AND-OR selection of the granted beat
  always_comb begin
    sel_oh_s   = '0;
    mux_data_s = '0;
    mux_last_s = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      sel_oh_s[k] = (SW'(k) == g_s);
      mux_data_s  = mux_data_s | (in_data[k*W +: W] & {W{sel_oh_s[k]}});
      mux_last_s  = mux_last_s | (in_last[k] & sel_oh_s[k]);
    end
  end

  assign in_ready = sel_oh_s & {N_CH{load_s & grant_ok_s & ~rst}};
  assign xfer_s   = |(in_valid & in_ready);

`ifdef STREAM_MUX_PKT_LOCK_EN
  // With locking the pointer only moves past a channel at end of packet.
  assign ptr_step_s = mux_last_s;
`else
  assign ptr_step_s = 1'b1;
`endif

  // Next-state for the output register, RR pointer and packet lock
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load_s) begin
      out_valid_d = xfer_s;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (xfer_s) begin
      out_data_d = mux_data_s;
      out_last_d = mux_last_s;
      out_ch_d   = g_s;
    end else begin
      // data registers hold so a stalled beat stays stable
      out_data_d = out_data_q;
    end
    if (xfer_s && (mode == MODE_RR) && ptr_step_s) begin
      ptr_d = SW'(next_ptr(32'(g_s), N_CH));
    end else begin
      ptr_d = ptr_q;
    end
`ifdef STREAM_MUX_PKT_LOCK_EN
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    if (xfer_s) begin
      lock_d    = ~mux_last_s;
      lock_ch_d = g_s;
    end else begin
      lock_d    = lock_q;
    end
`endif
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
`ifdef STREAM_MUX_PKT_LOCK_EN
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// -----------------------------------------------------------------------------
// tb_stream_mux_rr
// Directed, table-driven bench for stream_mux_rr (N_CH=4, W=8). Channel k
// always presents data 8'hA0 + 8'h11*k. Each table row gives inputs, the
// expected combinational in_ready, and the registered outputs after the edge.
// Hand-written sequences cover mid-stream reset and, with
// STREAM_MUX_PKT_LOCK_EN, packet locking.
// -----------------------------------------------------------------------------
module tb_stream_mux_rr;

  localparam int N_CH = 4;
  localparam int W    = 8;
`ifdef STREAM_MUX_PKT_LOCK_EN
  localparam bit LOCK_BUILD = 1'b1;
`else
  localparam bit LOCK_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_last;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.N_CH(N_CH), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] valid;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [7:0] exp_data;
    logic [1:0] exp_ch;
    logic       exp_last;
  } vec_t;

  vec_t tbl [25];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic ov, input logic [7:0] d,
                         input logic [1:0] ch, input logic lst);
    chk({nm, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({nm, ".out_data"},  32'(out_data),  32'(d));
    chk({nm, ".out_ch"},    32'(out_ch),    32'(ch));
    chk({nm, ".out_last"},  32'(out_last),  32'(lst));
  endtask

  initial begin
    // mode sel valid ordy | rdy ov data ch last   (in_last = 4'b0101)
    tbl[0]  = '{1'b0, 2'd0, 4'hF, 1'b1, 4'h1, 1'b1, 8'hA0, 2'd0, 1'b1};
    tbl[1]  = '{1'b0, 2'd1, 4'hF, 1'b1, 4'h2, 1'b1, 8'hB1, 2'd1, 1'b0};
    tbl[2]  = '{1'b0, 2'd2, 4'hF, 1'b1, 4'h4, 1'b1, 8'hC2, 2'd2, 1'b1};
    tbl[3]  = '{1'b0, 2'd3, 4'hF, 1'b1, 4'h8, 1'b1, 8'hD3, 2'd3, 1'b0};
    tbl[4]  = '{1'b1, 2'd3, 4'hF, 1'b1, 4'h1, 1'b1, 8'hA0, 2'd0, 1'b1};
    tbl[5]  = '{1'b1, 2'd3, 4'hF, 1'b1, 4'h2, 1'b1, 8'hB1, 2'd1, 1'b0};
    tbl[6]  = '{1'b1, 2'd3, 4'hF, 1'b1, 4'h4, 1'b1, 8'hC2, 2'd2, 1'b1};
    tbl[7]  = '{1'b1, 2'd3, 4'hF, 1'b1, 4'h8, 1'b1, 8'hD3, 2'd3, 1'b0};
    tbl[8]  = '{1'b1, 2'd3, 4'hF, 1'b1, 4'h1, 1'b1, 8'hA0, 2'd0, 1'b1};
    tbl[9]  = '{1'b1, 2'd3, 4'hF, 1'b1, 4'h2, 1'b1, 8'hB1, 2'd1, 1'b0};
    tbl[10] = '{1'b1, 2'd0, 4'hA, 1'b1, 4'h8, 1'b1, 8'hD3, 2'd3, 1'b0};
    tbl[11] = '{1'b1, 2'd0, 4'hA, 1'b1, 4'h2, 1'b1, 8'hB1, 2'd1, 1'b0};
    tbl[12] = '{1'b1, 2'd0, 4'hA, 1'b1, 4'h8, 1'b1, 8'hD3, 2'd3, 1'b0};
    tbl[13] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'h0, 1'b1, 8'hD3, 2'd3, 1'b0};
    tbl[14] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'h0, 1'b1, 8'hD3, 2'd3, 1'b0};
    tbl[15] = '{1'b1, 2'd0, 4'hF, 1'b0, 4'h0, 1'b1, 8'hD3, 2'd3, 1'b0};
    tbl[16] = '{1'b1, 2'd0, 4'hF, 1'b1, 4'h1, 1'b1, 8'hA0, 2'd0, 1'b1};
    tbl[17] = '{1'b1, 2'd0, 4'h0, 1'b1, 4'h0, 1'b0, 8'hA0, 2'd0, 1'b1};
    tbl[18] = '{1'b1, 2'd0, 4'h4, 1'b0, 4'h4, 1'b1, 8'hC2, 2'd2, 1'b1};
    tbl[19] = '{1'b1, 2'd0, 4'h1, 1'b0, 4'h0, 1'b1, 8'hC2, 2'd2, 1'b1};
    tbl[20] = '{1'b1, 2'd0, 4'h1, 1'b1, 4'h1, 1'b1, 8'hA0, 2'd0, 1'b1};
    tbl[21] = '{1'b0, 2'd2, 4'h1, 1'b1, 4'h4, 1'b0, 8'hA0, 2'd0, 1'b1};
    tbl[22] = '{1'b1, 2'd0, 4'hF, 1'b1, 4'h2, 1'b1, 8'hB1, 2'd1, 1'b0};
    tbl[23] = '{1'b0, 2'd0, 4'hF, 1'b1, 4'h1, 1'b1, 8'hA0, 2'd0, 1'b1};
    tbl[24] = '{1'b1, 2'd0, 4'hF, 1'b1, 4'h4, 1'b1, 8'hC2, 2'd2, 1'b1};

    rst       = 1'b1;
    mode      = 1'b0;
    sel       = 2'd0;
    in_data   = 32'hD3C2B1A0;
    in_last   = 4'h0;
    in_valid  = 4'h0;
    out_ready = 1'b0;

    // Reset state and in_ready gating during reset
    tick();
    tick();
    chk_out("reset", 1'b0, 8'h00, 2'd0, 1'b0);
    in_valid  = 4'hF;
    out_ready = 1'b1;
    #1;
    chk("reset.in_ready", 32'(in_ready), 32'h0);
    tick();
    rst = 1'b0;
    chk("reset_edge.out_valid", 32'(out_valid), 32'h0);

    // Table: fixed select, round-robin, backpressure, idle, mode switching
    for (int i = 0; i < 25; i++) begin
      mode      = tbl[i].mode;
      sel       = tbl[i].sel;
      in_valid  = tbl[i].valid;
      out_ready = tbl[i].ordy;
      in_last   = LOCK_BUILD ? 4'hF : 4'b0101;
      #1;
      chk($sformatf("row%0d.in_ready", i), 32'(in_ready), 32'(tbl[i].exp_rdy));
      tick();
      chk_out($sformatf("row%0d", i), tbl[i].exp_ov, tbl[i].exp_data, tbl[i].exp_ch,
              LOCK_BUILD ? 1'b1 : tbl[i].exp_last);
    end

    // Mid-stream reset: beat from ch1 with in_last=0 (sets lock when enabled)
    mode      = 1'b1;
    in_valid  = 4'b0010;
    in_last   = 4'h0;
    out_ready = 1'b1;
    #1;
    chk("pre_rst.in_ready", 32'(in_ready), 32'h2);
    tick();
    chk_out("pre_rst", 1'b1, 8'hB1, 2'd1, 1'b0);
    rst       = 1'b1;
    out_ready = 1'b0;
    in_valid  = 4'b1110;
    #1;
    chk("mid_rst.in_ready", 32'(in_ready), 32'h0);
    tick();
    rst = 1'b0;
    chk_out("post_rst", 1'b0, 8'h00, 2'd0, 1'b0);
    out_ready = 1'b1;
    #1;
    // pointer back at 0: first valid from 0 upward is ch1
    chk("post_rst.ptr_in_ready", 32'(in_ready), 32'h2);
    in_valid = 4'b1100;
    in_last  = 4'hF;
    #1;
    chk("post_rst.in_ready", 32'(in_ready), 32'h4);
    tick();
    chk_out("post_rst_beat", 1'b1, 8'hC2, 2'd2, 1'b1);

`ifdef STREAM_MUX_PKT_LOCK_EN
    // ptr now 3: ch0 wins, then holds the grant for its 3-beat packet
    in_valid = 4'b0011;
    for (int b = 0; b < 3; b++) begin
      in_last = (b == 2) ? 4'b0001 : 4'b0000;
      #1;
      chk($sformatf("lock_beat%0d.in_ready", b), 32'(in_ready), 32'h1);
      tick();
      chk_out($sformatf("lock_beat%0d", b), 1'b1, 8'hA0, 2'd0, (b == 2));
    end
    in_last = 4'hF;
    #1;
    chk("lock_release.in_ready", 32'(in_ready), 32'h2);
    tick();
    chk_out("lock_release", 1'b1, 8'hB1, 2'd1, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
